// File: rtl/seg7_hex_writer_pkg.sv
// Shared types and constants for the seg7 hex writer.
// FSM encodings, blank pattern and the hex-to-segment table.
package seg7_hex_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segments, bit0=a .. bit6=g
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_writer_if.sv
// Start/Ready request side plus the seg7 bank write bus.
// master = requester/bench, slave = writer.
interface seg7_hex_writer_if #(
    parameter int NDIG = 6
);
    logic                Start;
    logic [4*NDIG-1:0]   Value;
    logic                Ready;
    logic                Busy;
    logic                Done;
    logic                Sel;
    logic [2:0]          Addr;
    logic [6:0]          Data;

    modport master (
        output Start, Value,
        input  Ready, Busy, Done, Sel, Addr, Data
    );

    modport slave (
        input  Start, Value,
        output Ready, Busy, Done, Sel, Addr, Data
    );
endinterface

// File: rtl/seg7_hex_writer_hex7.sv
// Combinational nibble to active-high 7-segment pattern.
module seg7_hex_writer_hex7
    import seg7_hex_writer_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_TABLE[nib_i];

endmodule

// File: rtl/seg7_hex_writer.sv
// Writes a latched hex value to the seg7 bank, one digit per cycle.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_hex_writer
    import seg7_hex_writer_pkg::*;
#(
    parameter int NDIG = 6
) (
    input  logic               Clock,
    input  logic               Reset,
    seg7_hex_writer_if.slave   bus
);

    localparam logic [2:0] LAST = 3'(NDIG - 1);

    state_e              state_q;
    logic [2:0]          cnt_q;
    logic [4*NDIG-1:0]   value_q;

    logic [4*NDIG-1:0]   shifted;
    logic [3:0]          nib;
    logic [6:0]          seg;
    logic                blank;

    // Control FSM: accept in IDLE, one write per cycle, one DONE cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        value_q <= bus.Value;
                        cnt_q   <= '0;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign shifted = value_q >> {cnt_q, 2'b00};
    assign nib     = shifted[3:0];

    seg7_hex_writer_hex7 u_hex7 (
        .nib_i (nib),
        .seg_o (seg)
    );

`ifdef SEG7_LZB_EN
    // Digit 0 always shows, so a zero value still displays "0"
    assign blank = (cnt_q != 3'd0) && (shifted == '0);
`else
    assign blank = 1'b0;
`endif

    assign bus.Ready = (state_q == S_IDLE);
    assign bus.Busy  = (state_q == S_WRITE) || (state_q == S_DONE);
    assign bus.Done  = (state_q == S_DONE);
    assign bus.Sel   = (state_q == S_WRITE);
    assign bus.Addr  = bus.Sel ? cnt_q : 3'd0;
    assign bus.Data  = !bus.Sel ? SEG_BLANK :
                       blank    ? SEG_BLANK : seg;

endmodule

// File: tb/tb_seg7_hex_writer.sv
// Directed bench for seg7_hex_writer with a seg7 bank model.
// Build with +define+SEG7_LZB_EN to check blanking expectations.
module tb_seg7_hex_writer;

    logic Clock;
    logic Reset;

    seg7_hex_writer_if #(.NDIG(6)) bus ();

    seg7_hex_writer #(.NDIG(6)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int tests;
    int fails;

    // Bank model and bus-cycle log
    logic [6:0] bank [6];
    logic [2:0] wr_addr [128];
    logic [6:0] wr_data [128];
    int         wr_n;
    int         done_n;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (bus.Sel) begin
            if (bus.Addr < 3'd6) bank[bus.Addr] <= ~bus.Data;
            if (wr_n < 128) begin
                wr_addr[wr_n] = bus.Addr;
                wr_data[wr_n] = bus.Data;
            end
            wr_n = wr_n + 1;
        end
        if (bus.Done) done_n = done_n + 1;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        bus.Start = 1'b1;
        bus.Value = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.Sel !== 1'b0 || bus.Done !== 1'b0 ||
                bus.Busy !== 1'b0 || bus.Ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_hold%0d: sel=%b done=%b busy=%b rdy=%b want 0001",
                         i, bus.Sel, bus.Done, bus.Busy, bus.Ready);
            end
        end
        bus.Start = 1'b0;
        Reset     = 1'b0;
        tick();
        tests++;
        if (bus.Sel !== 1'b0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0 ||
            bus.Ready !== 1'b1 || bus.Addr !== 3'd0 || bus.Data !== 7'h00) begin
            fails++;
            $display("FAIL reset_release: sel=%b done=%b busy=%b rdy=%b addr=%0d data=%h",
                     bus.Sel, bus.Done, bus.Busy, bus.Ready, bus.Addr, bus.Data);
        end
    endtask

    // One complete update; exp holds digit i in bits [7*i+:7]
    task automatic run_update(input string nm, input logic [23:0] v,
                              input logic [41:0] exp, input bit pulse);
        int wb;
        int db;
        wb = wr_n;
        db = done_n;
        bus.Value = v;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Value = ~v;
        tests++;
        if (bus.Sel !== 1'b1 || bus.Busy !== 1'b1 || bus.Ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_accept: sel=%b busy=%b rdy=%b want 110",
                     nm, bus.Sel, bus.Busy, bus.Ready);
        end
        for (int i = 1; i < 6; i++) begin
            bus.Start = pulse && (i <= 3);
            tick();
        end
        bus.Start = 1'b0;
        tests++;
        if (bus.Sel !== 1'b1 || bus.Addr !== 3'd5) begin
            fails++;
            $display("FAIL %s_last: sel=%b addr=%0d want 1/5", nm, bus.Sel, bus.Addr);
        end
        tick();
        tests++;
        if (bus.Done !== 1'b1 || bus.Sel !== 1'b0 || bus.Busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: done=%b sel=%b busy=%b want 101",
                     nm, bus.Done, bus.Sel, bus.Busy);
        end
        tick();
        tests++;
        if (bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: rdy=%b done=%b busy=%b want 100",
                     nm, bus.Ready, bus.Done, bus.Busy);
        end
        tests++;
        if (wr_n - wb !== 6 || done_n - db !== 1) begin
            fails++;
            $display("FAIL %s_counts: writes=%0d dones=%0d want 6/1",
                     nm, wr_n - wb, done_n - db);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (wr_addr[wb+i] !== 3'(i) || wr_data[wb+i] !== exp[7*i+:7]) begin
                fails++;
                $display("FAIL %s_wr%0d: addr=%0d data=%h want %0d/%h",
                         nm, i, wr_addr[wb+i], wr_data[wb+i], i, exp[7*i+:7]);
            end
        end
    endtask

    task automatic test_basic();
        logic [41:0] e;
        e = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        run_update("basic", 24'h123456, e, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (bank[i] !== 7'(~e[7*i+:7])) begin
                fails++;
                $display("FAIL bank_H%0d: got %h want %h", i, bank[i], 7'(~e[7*i+:7]));
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_update("busy", 24'hABCDEF,
                   {7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}, 1'b1);
    endtask

    task automatic test_zeros();
`ifdef SEG7_LZB_EN
        run_update("lzb50", 24'h000050,
                   {7'h00, 7'h00, 7'h00, 7'h00, 7'h6D, 7'h3F}, 1'b0);
        run_update("lzb0", 24'h000000,
                   {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0);
`else
        run_update("nolzb50", 24'h000050,
                   {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h3F}, 1'b0);
        run_update("nolzb0", 24'h000000,
                   {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);
`endif
    endtask

    task automatic test_reset_abort();
        int db;
        db = done_n;
        bus.Value = 24'h123456;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (bus.Sel !== 1'b1 || bus.Addr !== 3'd3) begin
            fails++;
            $display("FAIL abort_pre: sel=%b addr=%0d want 1/3", bus.Sel, bus.Addr);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests++;
        if (bus.Sel !== 1'b0 || bus.Ready !== 1'b1 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_post: sel=%b rdy=%b busy=%b want 010",
                     bus.Sel, bus.Ready, bus.Busy);
        end
        tick();
        tick();
        tests++;
        if (done_n != db || bus.Sel !== 1'b0) begin
            fails++;
            $display("FAIL abort_nodone: dones=%0d sel=%b want 0/0", done_n - db, bus.Sel);
        end
        run_update("after_abort", 24'hABCDEF,
                   {7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [41:0] ea;
        logic [41:0] eb;
        int wb;
        int db;
        ea = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        eb = {7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        wb = wr_n;
        db = done_n;
        bus.Value = 24'h123456;
        bus.Start = 1'b1;
        tick();
        bus.Value = 24'hABCDEF;
        repeat (6) tick();
        tests++;
        if (bus.Done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done1: done=%b want 1", bus.Done);
        end
        tick();
        tests++;
        if (bus.Ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: rdy=%b want 1", bus.Ready);
        end
        tick();
        tests++;
        if (bus.Sel !== 1'b1 || bus.Data !== 7'h71) begin
            fails++;
            $display("FAIL b2b_accept2: sel=%b data=%h want 1/71", bus.Sel, bus.Data);
        end
        bus.Start = 1'b0;
        repeat (6) tick();
        tests++;
        if (bus.Done !== 1'b1 || done_n - db !== 1) begin
            fails++;
            $display("FAIL b2b_done2: done=%b prev=%0d want 1/1", bus.Done, done_n - db);
        end
        tick();
        tests++;
        if (wr_n - wb !== 12 || done_n - db !== 2) begin
            fails++;
            $display("FAIL b2b_counts: writes=%0d dones=%0d want 12/2",
                     wr_n - wb, done_n - db);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (wr_data[wb+i] !== ea[7*i+:7] || wr_data[wb+6+i] !== eb[7*i+:7]) begin
                fails++;
                $display("FAIL b2b_wr%0d: a=%h b=%h want %h/%h", i,
                         wr_data[wb+i], wr_data[wb+6+i], ea[7*i+:7], eb[7*i+:7]);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        wr_n      = 0;
        done_n    = 0;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Value = '0;
        test_reset();
        test_basic();
        test_start_while_busy();
        test_zeros();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
